blackjack_game_ctrl: RTL and testbench
======================================

// Module: blackjack_game_ctrl
// PURPOSE
// - Game sequencer; the requesting side of the card-dealing handshake. Drives o_Card2P/o_Card2D to
//   the card adder, waits for its i_CardOK, reads back the 6-bit hand totals and decides the game.
// - Sequence: initial deal P,D,P,D; player hit/stay; dealer draws below stand limit; compare.
// PARAMETERS
// - DEALER_STAND  17   dealer stops drawing when dealer hand >= this value
// - BUST_LIMIT    21   a hand > this value is bust
// - TIMEOUT_CYC   255  max cycles waiting on each handshake edge before ERROR (8-bit counter)
// PORTS
// - i_Clock      in   1  system clock, all logic on rising edge
// - i_Reset      in   1  synchronous, active-high reset
// - i_Start      in   1  1-cycle pulse: begin new game (honoured only in IDLE or DONE)
// - i_Hit        in   1  1-cycle pulse: player requests a card (honoured only in PLAYER)
// - i_Stay       in   1  1-cycle pulse: player stands (honoured only in PLAYER)
// - i_CardOK     in   1  card adder ack: card dealt and hand total updated
// - i_PlayerHnd  in   6  player hand total from card adder
// - i_DealerHnd  in   6  dealer hand total from card adder
// - o_HandClr    out  1  1-cycle pulse on accepted i_Start; clears card adder hands/address
// - o_Card2P     out  1  request one card to player (level)
// - o_Card2D     out  1  request one card to dealer (level)
// - o_Win/o_Lose/o_Tie out 1 each  result flags, valid (one-hot) in DONE only
// - o_Error      out  1  handshake timeout; sticky until reset or i_Start
// - o_PlayerTurn out  1  high in PLAYER (enables hit/stay LEDs)
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; deal counter, target, timeout counter 0. Applies mid-game.
// - States: IDLE, CLR, REQ, ACK_WAIT, REL_WAIT, EVAL, PLAYER, DEALER, COMPARE, DONE, ERROR.
// - IDLE/DONE/ERROR + i_Start -> CLR: o_HandClr=1 one cycle, results/o_Error cleared, deal_cnt=0.
// - CLR -> REQ with target = deal_cnt[0] ? dealer : player (P,D,P,D).
// - REQ (1 cycle): raise o_Card2P or o_Card2D per target, never both -> ACK_WAIT.
// - ACK_WAIT: request held; i_CardOK=1 -> drop request (registered, low next cycle), -> REL_WAIT.
// - REL_WAIT: request low; i_CardOK=0 -> EVAL. Hands sampled only in EVAL (adder totals final).
// - Timeout: counter reset on entering ACK_WAIT/REL_WAIT; reaching TIMEOUT_CYC -> ERROR, requests 0.
// - EVAL, deal phase (deal_cnt<3): deal_cnt++ -> REQ next target. deal_cnt==3: -> PLAYER.
// - EVAL, player target after deal: player>BUST_LIMIT -> DONE o_Lose; else -> PLAYER.
// - EVAL, dealer target after deal: -> DEALER.
// - PLAYER: i_Stay -> DEALER (i_Stay wins if i_Hit same cycle); i_Hit -> REQ target player.
// - DEALER: dealer<DEALER_STAND -> REQ target dealer; else -> COMPARE.
// - COMPARE: dealer>BUST_LIMIT -> Win; player>dealer -> Win; equal -> Tie; else Lose. -> DONE.
// - DONE: exactly one of o_Win/o_Lose/o_Tie held until reset or i_Start.
// - Compares unsigned 6-bit; totals up to 63 valid, no wrap handling needed.
// - i_CardOK outside ACK_WAIT/REL_WAIT ignored; i_Hit/i_Stay outside PLAYER dropped.
// - Latency: request asserted 1 cycle after REQ entry; game step per card >= 4 cycles + adder delay.
// CONFIGURATION
// - BJ_NATURAL_CHECK_EN defined: at deal_cnt==3 EVAL, player==21 -> COMPARE directly
//   (dealer 21 -> Tie, else Win), skipping PLAYER and DEALER.
// - Not defined: 21 after deal enters PLAYER as any other total.
// TESTING
// - Reset mid ACK_WAIT with o_Card2P=1 -> next cycle all outputs 0, state IDLE.
// - Start; adder acks 3 cyc after each req; hands P=18,D=10 after deal; Stay; dealer->20 -> o_Lose=1.
// - P=12,D=16 after deal; Hit -> P=25 -> o_Lose=1, no further o_Card2D pulse.
// - P=19,D=16; Stay; dealer card -> D=26 -> o_Win=1; P=D=18 after Stay -> o_Tie=1.
// - Never assert i_CardOK after request -> o_Error=1 after 255 cycles, o_Card2P=0.
// - Hit and Stay same cycle in PLAYER -> no o_Card2P, dealer phase begins; with
//   BJ_NATURAL_CHECK_EN, P=21,D=15 after deal -> o_Win=1 with no i_Stay.

Source files
------------

// File: rtl/blackjack_game_ctrl_if.sv
// Player controls, card-adder handshake and game results for blackjack_game_ctrl.
// The master modport is the game sequencer; the slave modport is its environment.
interface blackjack_game_ctrl_if;
  logic       i_Start;
  logic       i_Hit;
  logic       i_Stay;
  logic       i_CardOK;
  logic [5:0] i_PlayerHnd;
  logic [5:0] i_DealerHnd;
  logic       o_HandClr;
  logic       o_Card2P;
  logic       o_Card2D;
  logic       o_Win;
  logic       o_Lose;
  logic       o_Tie;
  logic       o_Error;
  logic       o_PlayerTurn;

  modport master (
    input  i_Start, i_Hit, i_Stay, i_CardOK, i_PlayerHnd, i_DealerHnd,
    output o_HandClr, o_Card2P, o_Card2D, o_Win, o_Lose, o_Tie, o_Error, o_PlayerTurn
  );

  modport slave (
    output i_Start, i_Hit, i_Stay, i_CardOK, i_PlayerHnd, i_DealerHnd,
    input  o_HandClr, o_Card2P, o_Card2D, o_Win, o_Lose, o_Tie, o_Error, o_PlayerTurn
  );
endinterface

// File: rtl/blackjack_game_ctrl.sv
// Blackjack game sequencer: deals via a request/ack handshake with the card adder and decides the game.
// Optional BJ_NATURAL_CHECK_EN: a player 21 after the initial deal goes straight to the comparison.
module blackjack_game_ctrl #(
  parameter logic [5:0] DEALER_STAND = 6'd17,
  parameter logic [5:0] BUST_LIMIT   = 6'd21,
  parameter logic [7:0] TIMEOUT_CYC  = 8'd255
) (
  input logic                   i_Clock,
  input logic                   i_Reset,
  blackjack_game_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CLR      = 4'd1,
    REQ      = 4'd2,
    ACK_WAIT = 4'd3,
    REL_WAIT = 4'd4,
    EVAL     = 4'd5,
    PLAYER   = 4'd6,
    DEALER   = 4'd7,
    COMPARE  = 4'd8,
    DONE     = 4'd9,
    ERROR    = 4'd10
  } state_t;

  localparam logic [5:0] NATURAL = 6'd21;

  state_t     state_r, state_s;
  logic [2:0] deal_cnt_r, deal_cnt_s;   // 0..3 during the deal, 4 once the deal is complete
  logic       target_r, target_s;       // 1'b0 player, 1'b1 dealer
  logic [7:0] tmo_r, tmo_s;
  logic [5:0] player_r, player_s;
  logic [5:0] dealer_r, dealer_s;
  logic       handclr_r, handclr_s;
  logic       card2p_r, card2p_s;
  logic       card2d_r, card2d_s;
  logic       win_r, win_s;
  logic       lose_r, lose_s;
  logic       tie_r, tie_s;
  logic       error_r, error_s;
  logic       turn_r, turn_s;

  // State register and registered outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r    <= IDLE;
      deal_cnt_r <= 3'd0;
      target_r   <= 1'b0;
      tmo_r      <= 8'd0;
      player_r   <= 6'd0;
      dealer_r   <= 6'd0;
      handclr_r  <= 1'b0;
      card2p_r   <= 1'b0;
      card2d_r   <= 1'b0;
      win_r      <= 1'b0;
      lose_r     <= 1'b0;
      tie_r      <= 1'b0;
      error_r    <= 1'b0;
      turn_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      deal_cnt_r <= deal_cnt_s;
      target_r   <= target_s;
      tmo_r      <= tmo_s;
      player_r   <= player_s;
      dealer_r   <= dealer_s;
      handclr_r  <= handclr_s;
      card2p_r   <= card2p_s;
      card2d_r   <= card2d_s;
      win_r      <= win_s;
      lose_r     <= lose_s;
      tie_r      <= tie_s;
      error_r    <= error_s;
      turn_r     <= turn_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    deal_cnt_s = deal_cnt_r;
    target_s   = target_r;
    tmo_s      = tmo_r;
    player_s   = player_r;
    dealer_s   = dealer_r;
    handclr_s  = 1'b0;
    card2p_s   = card2p_r;
    card2d_s   = card2d_r;
    win_s      = win_r;
    lose_s     = lose_r;
    tie_s      = tie_r;
    error_s    = error_r;

    case (state_r)
      IDLE, DONE, ERROR: begin
        if (bus.i_Start) begin
          state_s    = CLR;
          handclr_s  = 1'b1;
          win_s      = 1'b0;
          lose_s     = 1'b0;
          tie_s      = 1'b0;
          error_s    = 1'b0;
          deal_cnt_s = 3'd0;
        end else begin
          state_s = state_r;
        end
      end
      CLR: begin
        target_s = deal_cnt_r[0];
        state_s  = REQ;
      end
      REQ: begin
        card2p_s = ~target_r;
        card2d_s = target_r;
        tmo_s    = 8'd0;
        state_s  = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (bus.i_CardOK) begin
          card2p_s = 1'b0;
          card2d_s = 1'b0;
          tmo_s    = 8'd0;
          state_s  = REL_WAIT;
        end else if (tmo_r == TIMEOUT_CYC - 8'd1) begin
          card2p_s = 1'b0;
          card2d_s = 1'b0;
          error_s  = 1'b1;
          state_s  = ERROR;
        end else begin
          tmo_s = tmo_r + 8'd1;
        end
      end
      REL_WAIT: begin
        if (!bus.i_CardOK) begin
          state_s = EVAL;
        end else if (tmo_r == TIMEOUT_CYC - 8'd1) begin
          error_s = 1'b1;
          state_s = ERROR;
        end else begin
          tmo_s = tmo_r + 8'd1;
        end
      end
      EVAL: begin
        // Totals are final here: the adder has released its ack
        player_s = bus.i_PlayerHnd;
        dealer_s = bus.i_DealerHnd;
        if (deal_cnt_r < 3'd3) begin
          deal_cnt_s = deal_cnt_r + 3'd1;
          target_s   = ~deal_cnt_r[0];
          state_s    = REQ;
        end else if (deal_cnt_r == 3'd3) begin
          deal_cnt_s = 3'd4;
`ifdef BJ_NATURAL_CHECK_EN
          if (bus.i_PlayerHnd == NATURAL) begin
            state_s = COMPARE;
          end else begin
            state_s = PLAYER;
          end
`else
          state_s = PLAYER;
`endif
        end else if (!target_r) begin
          if (bus.i_PlayerHnd > BUST_LIMIT) begin
            lose_s  = 1'b1;
            state_s = DONE;
          end else begin
            state_s = PLAYER;
          end
        end else begin
          state_s = DEALER;
        end
      end
      PLAYER: begin
        if (bus.i_Stay) begin
          state_s = DEALER;
        end else if (bus.i_Hit) begin
          target_s = 1'b0;
          state_s  = REQ;
        end else begin
          state_s = PLAYER;
        end
      end
      DEALER: begin
        if (dealer_r < DEALER_STAND) begin
          target_s = 1'b1;
          state_s  = REQ;
        end else begin
          state_s = COMPARE;
        end
      end
      COMPARE: begin
        if (dealer_r > BUST_LIMIT) begin
          win_s = 1'b1;
        end else if (player_r > dealer_r) begin
          win_s = 1'b1;
        end else if (player_r == dealer_r) begin
          tie_s = 1'b1;
        end else begin
          lose_s = 1'b1;
        end
        state_s = DONE;
      end
      default: begin
        state_s  = IDLE;
        card2p_s = 1'b0;
        card2d_s = 1'b0;
      end
    endcase

    turn_s = (state_s == PLAYER);
  end

  assign bus.o_HandClr    = handclr_r;
  assign bus.o_Card2P     = card2p_r;
  assign bus.o_Card2D     = card2d_r;
  assign bus.o_Win        = win_r;
  assign bus.o_Lose       = lose_r;
  assign bus.o_Tie        = tie_r;
  assign bus.o_Error      = error_r;
  assign bus.o_PlayerTurn = turn_r;

endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// Scoreboard bench for blackjack_game_ctrl: scripted card adder, expected results queued per game.
module tb_blackjack_game_ctrl;

  localparam logic [3:0] R_WIN  = 4'b1000;
  localparam logic [3:0] R_LOSE = 4'b0100;
  localparam logic [3:0] R_TIE  = 4'b0010;
  localparam logic [3:0] R_ERR  = 4'b0001;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic ack_en;
  int   p_req_cnt;
  int   d_req_cnt;
  int   pcards[$];
  int   dcards[$];
  logic [3:0] sb[$];

  blackjack_game_ctrl_if bus ();

  blackjack_game_ctrl dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] result_vec();
    return {bus.o_Win, bus.o_Lose, bus.o_Tie, bus.o_Error};
  endfunction

  // Card adder model: acks each request two negedges after seeing it
  initial begin
    int ph;
    int dh;
    int card;
    logic is_d;
    ph = 0;
    dh = 0;
    bus.i_CardOK    = 1'b0;
    bus.i_PlayerHnd = 6'd0;
    bus.i_DealerHnd = 6'd0;
    forever begin
      @(negedge clk);
      if (bus.o_HandClr) begin
        ph = 0;
        dh = 0;
        bus.i_PlayerHnd = 6'd0;
        bus.i_DealerHnd = 6'd0;
      end else if (ack_en && !rst && (bus.o_Card2P || bus.o_Card2D)) begin
        is_d = bus.o_Card2D;
        chk("one_request", int'(bus.o_Card2P && bus.o_Card2D), 0);
        if (is_d) d_req_cnt++;
        else p_req_cnt++;
        repeat (2) @(negedge clk);
        chk("card_available", int'(is_d ? dcards.size() > 0 : pcards.size() > 0), 1);
        card = 0;
        if (is_d && dcards.size() > 0) card = dcards.pop_front();
        if (!is_d && pcards.size() > 0) card = pcards.pop_front();
        if (is_d) dh += card;
        else ph += card;
        bus.i_PlayerHnd = 6'(ph);
        bus.i_DealerHnd = 6'(dh);
        bus.i_CardOK = 1'b1;
        begin
          int n;
          n = 0;
          do begin
            @(negedge clk);
            n++;
          end while ((bus.o_Card2P || bus.o_Card2D) && n < 20);
          chk("request_dropped", int'(bus.o_Card2P || bus.o_Card2D), 0);
        end
        bus.i_CardOK = 1'b0;
      end
    end
  end

  // Result monitor: pops the scoreboard whenever a result or error flag appears
  initial begin
    logic [3:0] prev;
    logic [3:0] cur;
    logic [3:0] exp;
    prev = 4'd0;
    forever begin
      @(negedge clk);
      cur = result_vec();
      if (cur != 4'd0 && prev == 4'd0) begin
        chk("result_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          chk("result", int'(cur), int'(exp));
        end
      end
      prev = cur;
    end
  end

  task automatic start_game(input int p0, input int p1, input int d0, input int d1);
    pcards.delete();
    dcards.delete();
    pcards.push_back(p0);
    pcards.push_back(p1);
    dcards.push_back(d0);
    dcards.push_back(d1);
    p_req_cnt = 0;
    d_req_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.i_Start = 1'b1;
    @(negedge clk);
    bus.i_Start = 1'b0;
    chk("clr_cycle", int'({bus.o_HandClr, result_vec()}), int'(5'b10000));
    @(negedge clk);
    chk("clr_one_cycle", int'(bus.o_HandClr), 0);
  endtask

  task automatic press(input logic hit, input logic stay);
    @(negedge clk);
    bus.i_Hit  = hit;
    bus.i_Stay = stay;
    @(negedge clk);
    bus.i_Hit  = 1'b0;
    bus.i_Stay = 1'b0;
  endtask

  task automatic wait_turn();
    int n;
    n = 0;
    while (!bus.o_PlayerTurn && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("player_turn_reached", int'(bus.o_PlayerTurn), 1);
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (result_vec() == 4'd0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("game_finished", int'(result_vec() != 4'd0), 1);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    checks = 0;
    errors = 0;
    ack_en = 1'b1;
    p_req_cnt = 0;
    d_req_cnt = 0;
    bus.i_Start = 1'b0;
    bus.i_Hit   = 1'b0;
    bus.i_Stay  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({bus.o_HandClr, bus.o_Card2P, bus.o_Card2D, result_vec(), bus.o_PlayerTurn}), 0);
    rst = 1'b0;

    // Hit/Stay outside PLAYER are dropped
    press(1'b1, 1'b1);
    chk("idle_ignores_hit", int'({bus.o_Card2P, bus.o_Card2D, bus.o_PlayerTurn}), 0);

    // P=18, D=10; stay; dealer draws to 20 -> lose
    start_game(10, 8, 6, 4);
    dcards.push_back(10);
    sb.push_back(R_LOSE);
    pulse_start();
    wait_turn();
    press(1'b0, 1'b1);
    wait_result();

    // P=12, D=16; hit to 25 -> lose, dealer never draws again
    start_game(6, 6, 10, 6);
    pcards.push_back(13);
    sb.push_back(R_LOSE);
    pulse_start();
    wait_turn();
    press(1'b1, 1'b0);
    wait_result();
    chk("bust_dealer_reqs", d_req_cnt, 2);
    chk("bust_player_reqs", p_req_cnt, 3);

    // P=19, D=16; stay; dealer busts at 26 -> win
    start_game(10, 9, 10, 6);
    dcards.push_back(10);
    sb.push_back(R_WIN);
    pulse_start();
    wait_turn();
    press(1'b0, 1'b1);
    wait_result();

    // P=18, D=16; stay; dealer to 18 -> tie
    start_game(10, 8, 10, 6);
    dcards.push_back(2);
    sb.push_back(R_TIE);
    pulse_start();
    wait_turn();
    press(1'b0, 1'b1);
    wait_result();

    // P=15, D=17; hit and stay together -> stay wins, dealer stands -> lose
    start_game(10, 5, 10, 7);
    sb.push_back(R_LOSE);
    pulse_start();
    wait_turn();
    press(1'b1, 1'b1);
    wait_result();
    chk("hitstay_player_reqs", p_req_cnt, 2);
    chk("hitstay_dealer_reqs", d_req_cnt, 2);

    // P=21, D=15 after the deal
    start_game(10, 11, 10, 5);
    sb.push_back(R_WIN);
`ifdef BJ_NATURAL_CHECK_EN
    pulse_start();
    wait_result();
    chk("natural_dealer_reqs", d_req_cnt, 2);
`else
    dcards.push_back(5);
    pulse_start();
    wait_turn();
    press(1'b0, 1'b1);
    wait_result();
    chk("no_natural_dealer_reqs", d_req_cnt, 3);
`endif

    // Adder never acks -> error 255 cycles after the request rises
    ack_en = 1'b0;
    start_game(0, 0, 0, 0);
    sb.push_back(R_ERR);
    pulse_start();
    cnt = 0;
    while (!bus.o_Card2P && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_req_seen", int'(bus.o_Card2P), 1);
    cnt = 0;
    while (!bus.o_Error && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_cycles", cnt, 255);
    chk("timeout_req_low", int'({bus.o_Card2P, bus.o_Card2D}), 0);
    @(negedge clk);

    // Start clears the sticky error; then reset in the middle of ACK_WAIT
    pulse_start();
    cnt = 0;
    while (!bus.o_Card2P && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("midreset_req_seen", int'(bus.o_Card2P), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_outputs", int'({bus.o_HandClr, bus.o_Card2P, bus.o_Card2D, result_vec(), bus.o_PlayerTurn}), 0);
    repeat (5) @(negedge clk);
    chk("midreset_idle", int'({bus.o_Card2P, bus.o_Card2D, result_vec()}), 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
